piso_tx: RTL and testbench

PISO_TX -- requirements
Module: piso_tx

---
 rtl/piso_tx.sv | 74 +++++++
 tb/tb_piso_tx.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: captures a WIDTH-bit word on a valid/ready
// handshake and shifts it out one bit per clock, flagging the final bit with last.
module piso_tx #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] pi,
  output logic             load_ready,
  output logic             so,
  output logic             so_valid,
  output logic             last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_next;
  logic [CW-1:0]    cnt;
  logic             in_shift;
  logic             at_last;
  logic             take;
  logic             out_bit;

  assign in_shift = (state == SHIFT);
  assign at_last  = in_shift && (cnt == '0);
  assign take     = load_valid && load_ready;

  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign out_bit   = sreg[WIDTH-1];
      assign sreg_next = {sreg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign out_bit   = sreg[0];
      assign sreg_next = {1'b0, sreg[WIDTH-1:1]};
    end
  endgenerate

  // A handshake on the last bit reloads in place, so frames chain without an idle cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else if (take) begin
      state <= SHIFT;
      sreg  <= pi;
      cnt   <= CW'(WIDTH - 1);
    end else if (in_shift) begin
      sreg <= sreg_next;
      if (at_last) begin
        state <= IDLE;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign load_ready = !in_shift || at_last;
  assign so_valid   = in_shift;
  assign busy       = in_shift;
  assign last       = at_last;
  assign so         = in_shift && out_bit;

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx: three lanes (4-bit MSB-first, 4-bit LSB-first,
// 8-bit MSB-first) each with a frame-level reference model and an output monitor.
module tb_piso_tx;

  logic clk;
  int   n_checks;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input int lane, input string name,
                              input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL L%0d %s: got %h expected %h at %0t", lane, name, act, exp, $time);
    end
  endfunction

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int W   = (g == 2) ? 8 : 4;
    localparam int MSB = (g == 1) ? 0 : 1;

    logic         rst_n;
    logic         lv;
    logic [W-1:0] pi;
    logic         rdy, so, sov, lst, bsy;
    logic         done;

    logic [1:0]   bitq[$];   // {is_last, bit} per expected serial bit
    logic [31:0]  wordq[$];  // accepted words, in order
    int           mrem;      // frame bits still owed, counting the current cycle
    logic [31:0]  rebuilt;
    int unsigned  nb;

    piso_tx #(.WIDTH(W), .MSB_FIRST(MSB)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_valid (lv),
      .pi         (pi),
      .load_ready (rdy),
      .so         (so),
      .so_valid   (sov),
      .last       (lst),
      .busy       (bsy)
    );

    // Reference model: a word is accepted when offered while at most one bit is owed.
    initial begin
      mrem = 0;
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          mrem = 0;
          bitq.delete();
          wordq.delete();
        end else if (lv && mrem <= 1) begin
          for (int i = 0; i < W; i++)
            bitq.push_back({(i == W - 1), (MSB != 0) ? pi[W-1-i] : pi[i]});
          wordq.push_back(32'(pi));
          mrem = W;
        end else if (mrem > 0) begin
          mrem--;
        end
      end
    end

    // Monitor: compares every presented bit against the scoreboard and rebuilds words.
    initial begin
      rebuilt = '0;
      nb      = 0;
      forever begin
        @(negedge clk or negedge rst_n);
        if (!rst_n) begin
          rebuilt = '0;
          nb      = 0;
        end else begin
          chk(g, "load_ready", 32'(rdy), 32'(mrem <= 1));
          chk(g, "busy", 32'(bsy), 32'(mrem > 0));
          chk(g, "so_valid", 32'(sov), 32'(mrem > 0));
          if (sov) begin
            if (bitq.size() == 0) begin
              chk(g, "so_valid with nothing owed", 32'(sov), 32'd0);
            end else begin
              logic [1:0] e;
              e = bitq.pop_front();
              chk(g, "so", 32'(so), 32'(e[0]));
              chk(g, "last", 32'(lst), 32'(e[1]));
              if (MSB != 0) rebuilt = {rebuilt[30:0], so};
              else if (nb < 32) rebuilt[nb] = so;
              nb++;
              if (lst) begin
                logic [31:0] w;
                w = (wordq.size() > 0) ? wordq.pop_front() : 32'hdead_beef;
                chk(g, "rebuilt word", rebuilt, w);
                rebuilt = '0;
                nb      = 0;
              end
            end
          end else begin
            chk(g, "idle so", 32'(so), 32'd0);
            chk(g, "idle last", 32'(lst), 32'd0);
          end
        end
      end
    end

    task automatic reset_check();
      chk(g, "rst load_ready", 32'(rdy), 32'd1);
      chk(g, "rst so", 32'(so), 32'd0);
      chk(g, "rst so_valid", 32'(sov), 32'd0);
      chk(g, "rst last", 32'(lst), 32'd0);
      chk(g, "rst busy", 32'(bsy), 32'd0);
    endtask

    // Offer a word from a negedge; returns at the negedge after the accepting edge.
    task automatic offer(input logic [31:0] w, input bit hold);
      lv = 1'b1;
      pi = W'(w);
      while (mrem > 1) @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      if (!hold) lv = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
      lv = 1'b0;
      repeat (n) begin
        pi = W'($urandom);
        @(negedge clk);
      end
    endtask

    initial begin
      rst_n = 1'b0;
      lv    = 1'b0;
      pi    = '0;
      done  = 1'b0;
      #1 reset_check();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      offer(32'hB, 1'b0);
      idle(3);
      offer(32'h3, 1'b0);
      idle(2);

      // back-to-back with load_valid held high across the frame boundary
      offer(32'hB, 1'b1);
      offer(32'h4, 1'b0);
      idle(2);

      // offer a word while the block is mid-frame; it must be ignored
      offer(32'h0, 1'b0);
      idle(1);
      lv = 1'b1;
      pi = '1;
      repeat (2) @(negedge clk);
      lv = 1'b0;
      idle(W + 1);

      // reset during bit 2 of a frame, then silence until a new handshake
      offer(32'hA, 1'b0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 reset_check();
      @(negedge clk);
      rst_n = 1'b1;
      idle(4);

      // reset again, with a handshake offered on the very first edge after release
      #1 rst_n = 1'b0;
      #1 reset_check();
      @(negedge clk);
      rst_n = 1'b1;
      offer($urandom, 1'b0);
      idle(W + 1);

      for (int k = 0; k < 40; k++) begin
        offer($urandom, 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 2) == 0) idle($urandom_range(0, W + 1));
      end
      idle(W + 3);

      chk(g, "bits left in scoreboard", 32'(bitq.size()), 32'd0);
      chk(g, "words left in scoreboard", 32'(wordq.size()), 32'd0);
      done = 1'b1;
    end
  end

  initial begin
    int cyc;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    while (!(lane[0].done === 1'b1 && lane[1].done === 1'b1 && lane[2].done === 1'b1)
           && cyc < 40000) begin
      @(posedge clk);
      cyc++;
    end
    chk(-1, "all lanes finished", 32'(cyc < 40000), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
